// File: rtl/l2_bank_rr_arbiter.sv
// l2_bank_rr_arbiter: round-robin TCDM arbiter sharing one L2 bank; `define L2_ARB_PERF_CNT_EN adds grant/conflict counters
module l2_bank_rr_arbiter #(
  parameter int NB_MASTERS = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NB_MASTERS-1:0]               m_req_i,
  input  logic [NB_MASTERS*ADDR_WIDTH-1:0]    m_add_i,
  input  logic [NB_MASTERS-1:0]               m_wen_i,
  input  logic [NB_MASTERS*DATA_WIDTH/8-1:0]  m_be_i,
  input  logic [NB_MASTERS*DATA_WIDTH-1:0]    m_wdata_i,
  output logic [NB_MASTERS-1:0]               m_gnt_o,
  output logic [NB_MASTERS-1:0]               m_r_valid_o,
  output logic [DATA_WIDTH-1:0]               m_r_rdata_o,
  output logic                                bank_req_o,
  output logic [ADDR_WIDTH-1:0]               bank_add_o,
  output logic                                bank_wen_o,
  output logic [DATA_WIDTH/8-1:0]             bank_be_o,
  output logic [DATA_WIDTH-1:0]               bank_wdata_o,
  input  logic                                bank_gnt_i,
  input  logic                                bank_r_valid_i,
  input  logic [DATA_WIDTH-1:0]               bank_r_rdata_i
`ifdef L2_ARB_PERF_CNT_EN
  ,
  input  logic                                perf_clr_i,
  output logic [31:0]                         perf_grant_cnt_o,
  output logic [31:0]                         perf_conflict_cnt_o
`endif
);
  localparam int BW = DATA_WIDTH/8;
  localparam int IW = $clog2(NB_MASTERS);
  logic [IW-1:0] rr_ptr_q, id_q, win, idx;
  logic id_vld_q, any_req, gnt;
  always_comb begin
    win = rr_ptr_q;
    idx = rr_ptr_q;
    for (int i = NB_MASTERS-1; i >= 0; i--) begin
      idx = IW'((int'(rr_ptr_q) + i) % NB_MASTERS);
      if (m_req_i[idx]) win = idx;
    end
  end
  assign any_req      = |m_req_i;
  assign gnt          = bank_gnt_i & any_req;
  assign m_gnt_o      = gnt ? NB_MASTERS'(1) << win : '0;
  assign bank_req_o   = any_req;
  assign bank_add_o   = any_req ? m_add_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign bank_wen_o   = any_req & m_wen_i[win];
  assign bank_be_o    = any_req ? m_be_i[int'(win)*BW +: BW] : '0;
  assign bank_wdata_o = any_req ? m_wdata_i[int'(win)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign m_r_valid_o  = (bank_r_valid_i & id_vld_q) ? NB_MASTERS'(1) << id_q : '0;
  assign m_r_rdata_o  = bank_r_rdata_i;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      rr_ptr_q <= '0;
      id_q     <= '0;
      id_vld_q <= 1'b0;
    end else begin
      id_vld_q <= gnt;
      if (gnt) begin
        rr_ptr_q <= (win == IW'(NB_MASTERS-1)) ? '0 : win + 1'b1;
        id_q     <= win;
      end
    end
`ifdef L2_ARB_PERF_CNT_EN
  logic conflict;
  assign conflict = bank_gnt_i & ($countones(m_req_i) > 1);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      perf_grant_cnt_o    <= '0;
      perf_conflict_cnt_o <= '0;
    end else begin
      perf_grant_cnt_o    <= perf_clr_i ? '0 : perf_grant_cnt_o + 32'(gnt & ~&perf_grant_cnt_o);
      perf_conflict_cnt_o <= perf_clr_i ? '0 : perf_conflict_cnt_o + 32'(conflict & ~&perf_conflict_cnt_o);
    end
`endif
endmodule

// File: tb/tb_l2_bank_rr_arbiter.sv
// tb_l2_bank_rr_arbiter: randomized scoreboard bench against a round-robin reference model
module tb_l2_bank_rr_arbiter;
  localparam int NB = 4;
  logic clk = 1'b0, rst_ni = 1'b0;
  logic [NB-1:0] m_req_i = '0, m_wen_i = '0, m_gnt_o, m_r_valid_o;
  logic [NB*32-1:0] m_add_i = '0, m_wdata_i = '0;
  logic [NB*4-1:0] m_be_i = '0;
  logic [31:0] m_r_rdata_o, bank_add_o, bank_wdata_o, bank_r_rdata_i = '0;
  logic bank_req_o, bank_wen_o, bank_gnt_i = 1'b0, bank_r_valid_i = 1'b0;
  logic [3:0] bank_be_o;
`ifdef L2_ARB_PERF_CNT_EN
  logic perf_clr_i = 1'b0;
  logic [31:0] perf_grant_cnt_o, perf_conflict_cnt_o;
  int gc = 0, cc = 0;
`endif
  l2_bank_rr_arbiter #(.NB_MASTERS(NB), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .m_req_i(m_req_i), .m_add_i(m_add_i), .m_wen_i(m_wen_i), .m_be_i(m_be_i), .m_wdata_i(m_wdata_i),
    .m_gnt_o(m_gnt_o), .m_r_valid_o(m_r_valid_o), .m_r_rdata_o(m_r_rdata_o),
    .bank_req_o(bank_req_o), .bank_add_o(bank_add_o), .bank_wen_o(bank_wen_o), .bank_be_o(bank_be_o),
    .bank_wdata_o(bank_wdata_o), .bank_gnt_i(bank_gnt_i), .bank_r_valid_i(bank_r_valid_i),
    .bank_r_rdata_i(bank_r_rdata_i)
`ifdef L2_ARB_PERF_CNT_EN
    , .perf_clr_i(perf_clr_i), .perf_grant_cnt_o(perf_grant_cnt_o), .perf_conflict_cnt_o(perf_conflict_cnt_o)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {int due; int id; logic [31:0] dat;} rsp_t;
  rsp_t sbq[$];
  int total = 0, bad = 0, cyc = 0, ptr = 0;
  logic [NB-1:0] hold = '0;
  logic prev_acc = 1'b0;
  logic [31:0] nxt_rdata = '0;
  logic [31:0] add[NB], wdat[NB];
  logic [3:0] be[NB];
  logic wen[NB];
  task automatic chk(input string n, input logic [95:0] a, input logic [95:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", n, cyc, a, e);
    end
  endtask
  // One clock cycle of stimulus; the reference model picks the first requester from ptr upward.
  task automatic step(input logic [NB-1:0] req, input logic bg, input int exp_g);
    int w;
    logic [NB-1:0] eg;
    @(posedge clk);
    cyc++;
    #1;
    for (int k = 0; k < NB; k++) begin
      if (!hold[k]) begin
        add[k] = $urandom;
        wdat[k] = $urandom;
        be[k] = 4'($urandom);
        wen[k] = 1'($urandom);
      end
      m_add_i[k*32 +: 32] = add[k];
      m_wdata_i[k*32 +: 32] = wdat[k];
      m_be_i[k*4 +: 4] = be[k];
      m_wen_i[k] = wen[k];
    end
    m_req_i = req;
    bank_gnt_i = bg;
    bank_r_valid_i = prev_acc | ($urandom_range(0, 7) == 0);
    bank_r_rdata_i = nxt_rdata;
    #3;
    w = -1;
    for (int o = 0; o < NB; o++)
      if (w < 0 && req[(ptr + o) % NB]) w = (ptr + o) % NB;
    eg = (w >= 0 && bg) ? NB'(1 << w) : '0;
    chk("gnt", m_gnt_o, eg);
    if (exp_g >= 0) chk("gnt_directed", m_gnt_o, exp_g);
    chk("bank_req", bank_req_o, w >= 0);
    if (w >= 0) chk("bank_payload", {bank_add_o, bank_wen_o, bank_be_o, bank_wdata_o}, {add[w], wen[w], be[w], wdat[w]});
    else chk("bank_idle", {bank_add_o, bank_wen_o, bank_be_o, bank_wdata_o}, '0);
`ifdef L2_ARB_PERF_CNT_EN
    chk("perf_grant", perf_grant_cnt_o, gc);
    chk("perf_conflict", perf_conflict_cnt_o, cc);
    if (perf_clr_i) begin
      gc = 0;
      cc = 0;
    end else begin
      gc += int'(w >= 0 && bg);
      cc += int'(bg && $countones(req) > 1);
    end
`endif
    nxt_rdata = $urandom;
    prev_acc = (w >= 0) && bg;
    hold = req & ~eg;
    if (prev_acc) begin
      sbq.push_back('{cyc + 1, w, nxt_rdata});
      ptr = (w + 1) % NB;
    end
  endtask
  always @(negedge clk)
    if (rst_ni && cyc > 0) begin
      logic [NB-1:0] ev;
      logic [31:0] ed;
      rsp_t r;
      ev = '0;
      ed = '0;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        r = sbq.pop_front();
        ev = NB'(1 << r.id);
        ed = r.dat;
      end
      chk("r_valid", m_r_valid_o, ev);
      if (ev != '0) chk("r_rdata", m_r_rdata_o, ed);
    end
  initial begin
    for (int k = 0; k < NB; k++) begin
      add[k] = $urandom;
      wdat[k] = $urandom;
      be[k] = 4'($urandom);
      wen[k] = 1'($urandom);
    end
    bank_r_valid_i = 1'b1;
    #2;
    chk("rst_r_valid", m_r_valid_o, '0);
    chk("rst_gnt", m_gnt_o, '0);
    chk("rst_bank_req", bank_req_o, 1'b0);
    chk("rst_bank_payload", {bank_add_o, bank_wen_o, bank_be_o, bank_wdata_o}, '0);
    bank_r_valid_i = 1'b0;
    #10 rst_ni = 1'b1;
    add[0] = 32'h1C01_0000;
    hold[0] = 1'b1;
    step(4'b0001, 1'b1, 4'b0001);
    step(4'b0011, 1'b1, 4'b0010);
    for (int i = 0; i < 6; i++) step(4'b0011, 1'b1, (i % 2 == 0) ? 4'b0001 : 4'b0010);
    for (int i = 0; i < 3; i++) step(4'b0110, 1'b0, 4'b0000);
    step(4'b0110, 1'b1, 4'b0100);
    step(4'b0101, 1'b1, 4'b0001);
    step(4'b0101, 1'b1, 4'b0100);
    step(4'b0101, 1'b1, 4'b0001);
    step(4'b0100, 1'b1, 4'b0100);
    @(posedge clk);
    cyc++;
    #1;
    m_req_i = '0;
    bank_r_valid_i = 1'b1;
    bank_r_rdata_i = nxt_rdata;
    #1;
    chk("pre_rst_r_valid", m_r_valid_o, 4'b0100);
    rst_ni = 1'b0;
    #1;
    chk("async_rst_r_valid", m_r_valid_o, '0);
    sbq.delete();
    ptr = 0;
    prev_acc = 1'b0;
    hold = '0;
`ifdef L2_ARB_PERF_CNT_EN
    gc = 0;
    cc = 0;
`endif
    @(negedge clk);
    #1 rst_ni = 1'b1;
    step(4'b0010, 1'b1, 4'b0010);
    step(4'b1001, 1'b1, 4'b1000);
    step(4'b1001, 1'b1, 4'b0001);
    for (int i = 0; i < 2000; i++) begin
`ifdef L2_ARB_PERF_CNT_EN
      perf_clr_i = ($urandom_range(0, 63) == 0);
`endif
      step(hold | (NB'($urandom) & NB'($urandom)), $urandom_range(0, 3) != 0, -1);
    end
    step('0, 1'b0, 4'b0000);
    step('0, 1'b0, 4'b0000);
    chk("scoreboard_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/l2_bank_rr_arbiter.md
Name: l2_bank_rr_arbiter

Overview:
- Shares one single-ported L2 SRAM bank (TCDM slave protocol, constant 1-cycle read latency) between NB_MASTERS TCDM requesters.
- Grants with fair round-robin arbitration, forwards the winning request to the bank, and routes the bank response back to the granted master.
- Placed in front of a private L2 bank so core data and a DMA/debug port can share it without a full crossbar.

Parameters:
- NB_MASTERS, 2, number of requesters; legal range 2..8.
- ADDR_WIDTH, 32, byte address width on master and bank sides.
- DATA_WIDTH, 32, data width; byte-enable width is DATA_WIDTH/8.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- m_req_i  in  NB_MASTERS  per-master request.
- m_add_i  in  NB_MASTERS*ADDR_WIDTH  per-master byte address; master k occupies slice k.
- m_wen_i  in  NB_MASTERS  per-master write-enable, active-low (1 = read, 0 = write).
- m_be_i  in  NB_MASTERS*DATA_WIDTH/8  per-master byte enables.
- m_wdata_i  in  NB_MASTERS*DATA_WIDTH  per-master write data.
- m_gnt_o  out  NB_MASTERS  per-master grant, combinational.
- m_r_valid_o  out  NB_MASTERS  per-master response valid.
- m_r_rdata_o  out  DATA_WIDTH  response data, broadcast to all masters; qualified by m_r_valid_o.
- bank_req_o  out  1  bank request.
- bank_add_o  out  ADDR_WIDTH  bank address.
- bank_wen_o  out  1  bank write-enable, active-low.
- bank_be_o  out  DATA_WIDTH/8  bank byte enables.
- bank_wdata_o  out  DATA_WIDTH  bank write data.
- bank_gnt_i  in  1  bank grant.
- bank_r_valid_i  in  1  bank response valid, exactly 1 cycle after an accepted request.
- bank_r_rdata_i  in  DATA_WIDTH  bank read data.

Behaviour:
Arbitration:
- Combinational. Search m_req_i starting at index rr_ptr_q, upward with wrap-around modulo NB_MASTERS. The first requester found is the winner w.
- bank_req_o = |m_req_i. The bank add/wen/be/wdata outputs are muxed from w.
- When no request is pending, bank_add_o, bank_wen_o, bank_be_o and bank_wdata_o output 0.

Grant:
- m_gnt_o[w] = bank_gnt_i & m_req_i[w]. All other m_gnt_o bits are 0. At most one grant per cycle.
- Masters hold their request stable until granted. The arbiter never grants a master whose req is low.

Pointer update:
- On a cycle with a granted transfer, rr_ptr_q <= (w+1) mod NB_MASTERS.
- Without a grant (no request, or bank_gnt_i = 0), rr_ptr_q holds. The winner can therefore change while the bank stalls; this is legal because no grant was issued.
- Reset value: rr_ptr_q = 0.

Response routing:
- On a granted transfer, id_q <= w and id_vld_q <= 1. Otherwise id_vld_q <= 0.
- m_r_valid_o[k] = bank_r_valid_i & id_vld_q & (id_q == k).
- m_r_rdata_o = bank_r_rdata_i.
- Writes also produce r_valid (bank convention).
- Latency: request accepted at edge N; response to that master in cycle N+1. Throughput is one transfer per cycle.

Boundary conditions:
- Back-to-back: a master granted in cycle N may be granted again in N+1 only if no other master requests in N+1.
- bank_r_valid_i asserted while id_vld_q = 0 (protocol error): ignored, all m_r_valid_o = 0.
- Reset mid-operation: rr_ptr_q = 0, id_vld_q = 0, and all m_r_valid_o = 0 immediately (asynchronous). An in-flight response is dropped.

Reset values:
- m_gnt_o and bank_req_o follow inputs; they are 0 if no requests.
- m_r_valid_o = 0.

Optional Feature:
- Macro: L2_ARB_PERF_CNT_EN.
- With the macro defined, add these ports:
  - perf_clr_i  in  1  synchronous clear.
  - perf_grant_cnt_o  out  32  counts granted transfers.
  - perf_conflict_cnt_o  out  32  counts cycles with bank_gnt_i & (two or more m_req_i high).
- Both counters reset to 0, saturate at 0xFFFFFFFF, and clear on perf_clr_i. Clear has priority over increment in the same cycle.
- Without the macro: ports and counters are absent; arbitration behaviour is identical.

Test Plan:
1. Reset, then a single read: m_req_i=2'b01, add=0x1C010000, bank_gnt_i=1 -> m_gnt_o=01 same cycle; next cycle m_r_valid_o=01, rdata=bank_r_rdata_i; rr_ptr=1.
2. Continuous contention: m_req_i=2'b11 held for 6 cycles, bank_gnt_i=1 -> grants alternate 01,10,01,10,01,10; each r_valid follows its grant by exactly 1 cycle.
3. Bank stall: m_req_i=2'b11, bank_gnt_i=0 for 3 cycles, then 1 -> m_gnt_o=00 for 3 cycles, rr_ptr unchanged, first grant goes to the master at rr_ptr.
4. NB_MASTERS=4 wrap-around: rr_ptr=3, m_req_i=4'b0101 -> grant master 0, then master 2, then master 0.
5. Async reset asserted the cycle after a grant -> m_r_valid_o=0 immediately, rr_ptr=0; after release, the first request from master 1 alone is granted at once.
6. With L2_ARB_PERF_CNT_EN: 10 cycles of m_req_i=2'b11 -> grant_cnt=10, conflict_cnt=10; perf_clr_i asserted together with a grant -> both counters read 0 next cycle.
